// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: op encodings, FSM states, flag bundle.
package alu_arbiter_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
    logic size;
  } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the ALU arbiter; master = requesters + response sink, slave = arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;
  logic              resp_overflow;
  logic              resp_carry;
  logic              resp_size;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result,
    input  resp_zero, resp_overflow, resp_carry, resp_size
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result,
    output resp_zero, resp_overflow, resp_carry, resp_size
  );

endinterface

// File: rtl/alu_arbiter_alu4_core.sv
// Combinational 4-bit ALU shared by both requesters of alu_arbiter.
module alu4_core
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    // carry out of a + ~b + 1 is the "no borrow" indication
    diff_w = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    result = '0;
    flags  = '0;
    case (alu_op_t'(op))
      OP_ADD: begin
        result         = sum_w[DATA_W-1:0];
        flags.carry    = sum_w[DATA_W];
        flags.overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB, OP_SLT, OP_EQ: begin
        result         = diff_w[DATA_W-1:0];
        flags.carry    = diff_w[DATA_W];
        flags.overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff_w[DATA_W-1] != a[DATA_W-1]);
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
    flags.zero = (result == '0);
    if (alu_op_t'(op) == OP_SLT)
      flags.size = result[DATA_W-1] ^ flags.overflow;
    else if (alu_op_t'(op) == OP_EQ)
      flags.size = (a == b);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters, one op in flight.
// Optional grant statistics counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  arb_state_t        state;
  logic              ptr;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] alu_result;
  alu_flags_t        alu_flags;

  logic              vld_p1;
  logic              id_p1;
  logic [DATA_W-1:0] result_p1;
  alu_flags_t        flags_p1;

  // p0: arbitration and operand select, same cycle as the request
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr);
      gnt1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
  assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;

  alu4_core u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // p1: response register, held until the sink takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      vld_p1    <= 1'b0;
      id_p1     <= 1'b0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            state     <= S_RESP;
            vld_p1    <= 1'b1;
            id_p1     <= gnt1;
            result_p1 <= alu_result;
            flags_p1  <= alu_flags;
            ptr       <= gnt0;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state  <= S_IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid    = vld_p1;
  assign bus.resp_id       = id_p1;
  assign bus.resp_result   = result_p1;
  assign bus.resp_zero     = flags_p1.zero;
  assign bus.resp_overflow = flags_p1.overflow;
  assign bus.resp_carry    = flags_p1.carry;
  assign bus.resp_size     = flags_p1.size;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (gnt1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

  // Ready is only raised for a valid source, so the transfer completes while valid is held
  a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n) bus.req0_ready |-> bus.req0_valid);
  a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n) bus.req1_ready |-> bus.req1_valid);
  a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 && !bus.resp_ready) |=> (vld_p1 && $stable(result_p1) && $stable(flags_p1) && $stable(id_p1)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter (default build and ALU_ARB_STATS_EN build).
module tb_alu_arbiter;

`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] gc0;
  logic [CNT_W-1:0] gc1;
`endif

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] op1;
    logic       id;
    logic [3:0] res;
    logic [3:0] flg;   // {zero, overflow, carry, size}
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] resp_flags();
    return {bus.resp_zero, bus.resp_overflow, bus.resp_carry, bus.resp_size};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_op = v.op0;
    bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_op = v.op1;
    bus.resp_ready = 1'b1;
    #1;
    chk({tag, ".ready0"}, 32'(bus.req0_ready), 32'(v.id == 1'b0));
    chk({tag, ".ready1"}, 32'(bus.req1_ready), 32'(v.id == 1'b1));
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, ".resp_id"},    32'(bus.resp_id),    32'(v.id));
    chk({tag, ".result"},     32'(bus.resp_result), 32'(v.res));
    chk({tag, ".flags"},      32'(resp_flags()),    32'(v.flg));
    tick();
    chk({tag, ".idle"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic set_req0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic set_req1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  initial begin
    //          v0   a0       b0       op0     v1   a1       b1       op1     id   res      flg
    vecs[0] = '{1'b1, 4'b0111, 4'b0001, 3'b000, 1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, 4'b1000, 4'b0100};
    vecs[1] = '{1'b1, 4'b1100, 4'b1010, 3'b011, 1'b1, 4'b0011, 4'b0101, 3'b001, 1'b1, 4'b1110, 4'b0000};
    vecs[2] = '{1'b1, 4'b1010, 4'b0101, 3'b100, 1'b1, 4'b0110, 4'b0011, 3'b101, 1'b0, 4'b1111, 4'b0000};
    vecs[3] = '{1'b1, 4'b0000, 4'b0000, 3'b010, 1'b1, 4'b1110, 4'b0001, 3'b110, 1'b1, 4'b1101, 4'b0011};
    vecs[4] = '{1'b1, 4'b0101, 4'b0101, 3'b111, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0, 4'b0000, 4'b1011};
    vecs[5] = '{1'b1, 4'b1111, 4'b0001, 3'b000, 1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, 4'b0000, 4'b1010};
    vecs[6] = '{1'b0, 4'b0000, 4'b0000, 3'b000, 1'b1, 4'b0110, 4'b0110, 3'b101, 1'b1, 4'b0000, 4'b1000};
    vecs[7] = '{1'b0, 4'b0000, 4'b0000, 3'b000, 1'b1, 4'b1000, 4'b0001, 3'b001, 1'b1, 4'b0111, 4'b0110};
    vecs[8] = '{1'b1, 4'b0001, 4'b1110, 3'b110, 1'b1, 4'b1111, 4'b1111, 3'b011, 1'b0, 4'b0011, 4'b0000};
    vecs[9] = '{1'b1, 4'b0000, 4'b0000, 3'b000, 1'b1, 4'b0110, 4'b0011, 3'b011, 1'b1, 4'b0010, 4'b0000};

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.resp_ready = 1'b1;
    set_req0(4'b0001, 4'b0001, 3'b000);
    set_req1(4'b0010, 4'b0010, 3'b000);

    // Reset state, with both sources requesting while reset is held
    repeat (2) tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rst.ready0",     32'(bus.req0_ready),  32'd0);
    chk("rst.ready1",     32'(bus.req1_ready),  32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid),  32'd0);
    chk("rst.resp_id",    32'(bus.resp_id),     32'd0);
    chk("rst.result",     32'(bus.resp_result), 32'd0);
    chk("rst.flags",      32'(resp_flags()),    32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst.cnt0", 32'(gc0), 32'd0);
    chk("rst.cnt1", 32'(gc1), 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    // Both requesters held valid from reset: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d.ready0", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d.ready1", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
      tick();
      chk($sformatf("rr%0d.resp_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("rr%0d.resp_id", k),    32'(bus.resp_id),    32'(k % 2));
      chk($sformatf("rr%0d.result", k),     32'(bus.resp_result), ((k % 2) == 0) ? 32'h2 : 32'h4);
      chk($sformatf("rr%0d.ready_busy", k), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      tick();
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Stalled response: held stable, readies low, then one handshake and back to IDLE
    set_req0(4'b0011, 4'b0100, 3'b000);
    set_req1(4'b1111, 4'b1010, 3'b011);
    bus.req0_valid = 1'b1;
    bus.resp_ready = 1'b0;
    tick();
    bus.req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d.resp_valid", c), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("stall%0d.result", c),     32'(bus.resp_result), 32'h7);
      chk($sformatf("stall%0d.id", c),         32'(bus.resp_id),     32'd0);
      chk($sformatf("stall%0d.readies", c),    32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("stall.hs_readies", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    tick();
    chk("stall.idle_valid", 32'(bus.resp_valid), 32'd0);
    chk("stall.next_ready1", 32'(bus.req1_ready), 32'd1);
    chk("stall.next_ready0", 32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b0;
    chk("stall.next_id",     32'(bus.resp_id),     32'd1);
    chk("stall.next_result", 32'(bus.resp_result), 32'ha);
    tick();

    // Reset while a response is pending (pointer was moved to 1 by the grant to req0)
    set_req0(4'b0010, 4'b0011, 3'b000);
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    bus.resp_ready = 1'b0;
    chk("rr_mid.pending", 32'(bus.resp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rr_mid.resp_valid", 32'(bus.resp_valid),  32'd0);
    chk("rr_mid.result",     32'(bus.resp_result), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rr_mid.cnt0", 32'(gc0), 32'd0);
    chk("rr_mid.cnt1", 32'(gc1), 32'd0);
`endif
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rr_mid.ready_in_rst", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    chk("rr_mid.ptr_ready0", 32'(bus.req0_ready), 32'd1);
    chk("rr_mid.ptr_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("rr_mid.grant_id", 32'(bus.resp_id),     32'd0);
    chk("rr_mid.result2",  32'(bus.resp_result), 32'h5);
    tick();

`ifdef ALU_ARB_STATS_EN
    // Saturation of a 2-bit counter after five grants to req0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req0(4'b0000, 4'b0000, 3'b000);
    for (int g = 0; g < 5; g++) begin
      bus.req0_valid = 1'b1;
      tick();
      bus.req0_valid = 1'b0;
      tick();
    end
    chk("stats.cnt0", 32'(gc0), 32'd3);
    chk("stats.cnt1", 32'(gc1), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
